// File: rtl/branch_update_unit.sv
// rtl/branch_update_unit.sv - branch prediction tracking, mispredict detection and table update FIFO
//
// Purpose:
//   Carries each fetch-time prediction down a STAGES-deep tracking pipeline
//   to execute, compares it with the resolved outcome, raises a registered
//   one-cycle mispredict/redirect, and queues training updates into a small
//   FIFO that drives the prediction table's write port.
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   fetch_valid/pc/pred_taken/pred_target   fetch-time prediction
//   stall                 freezes tracking pipeline, suppresses evaluation
//   ex_valid/ex_is_branch/ex_taken/ex_target  resolved execute outcome
//   mispredict, redirect_pc                   registered flush/redirect pulse
//   upd_write/pc/result/address, upd_ready    table write port (FIFO head)
//   fifo_full, dropped_count                  FIFO status, saturating drops
module branch_update_unit #(
   parameter int STAGES     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        fetch_valid,
   input  logic [31:0] fetch_pc,
   input  logic        pred_taken,
   input  logic [31:0] pred_target,
   input  logic        stall,
   input  logic        ex_valid,
   input  logic        ex_is_branch,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   output logic        mispredict,
   output logic [31:0] redirect_pc,
   output logic        upd_write,
   output logic [31:0] upd_pc,
   output logic        upd_result,
   output logic [31:0] upd_address,
   input  logic        upd_ready,
   output logic        fifo_full,
   output logic [15:0] dropped_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   // Tracking pipeline; index STAGES-1 is the tail (execute instruction)
   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] pt_q;
   logic [31:0]       pc_q   [STAGES];
   logic [31:0]       ptgt_q [STAGES];

   logic        mispredict_q, mispredict_d;
   logic [31:0] redirect_q, redirect_d;

   // Evaluation
   logic        eval;
   logic [31:0] tail_pc, tail_ptgt, seq_pc, pred_next, act_next;
   logic        tail_pt;
   logic        push;
   logic        push_res;
   logic [31:0] push_addr;

   // Update FIFO
   logic [31:0]   mem_pc   [FIFO_DEPTH];
   logic          mem_res  [FIFO_DEPTH];
   logic [31:0]   mem_addr [FIFO_DEPTH];
   logic [PW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   dropped_q;
   logic          not_empty, full, pop, accept, drop;

   assign tail_pc   = pc_q[STAGES-1];
   assign tail_pt   = pt_q[STAGES-1];
   assign tail_ptgt = ptgt_q[STAGES-1];

   always_comb begin
      eval         = !stall && ex_valid && v_q[STAGES-1];
      seq_pc       = tail_pc + 32'd4;
      pred_next    = tail_pt ? tail_ptgt : seq_pc;
      act_next     = ex_taken ? ex_target : seq_pc;
      mispredict_d = 1'b0;
      redirect_d   = redirect_q;
      push         = 1'b0;
      push_res     = 1'b0;
      push_addr    = 32'd0;
      if (eval) begin
         if (ex_is_branch) begin
            push      = 1'b1;
            push_res  = ex_taken;
            push_addr = ex_target;
            if (pred_next != act_next) begin
               mispredict_d = 1'b1;
               redirect_d   = act_next;
            end
         end else if (tail_pt) begin
            // Aliased non-branch predicted taken: redirect to fall-through
            // and train the entry down to not-taken.
            mispredict_d = 1'b1;
            redirect_d   = seq_pc;
            push         = 1'b1;
            push_addr    = seq_pc;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         v_q <= '0;
      end else if (!stall) begin
         v_q[0] <= fetch_valid;
         for (int k = 1; k < STAGES; k++) begin
            v_q[k] <= v_q[k-1];
         end
         // Flush wins over the shift, including the entry coming in
         if (mispredict_d) begin
            v_q <= '0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!stall) begin
         pc_q[0]   <= fetch_pc;
         pt_q[0]   <= pred_taken;
         ptgt_q[0] <= pred_target;
         for (int k = 1; k < STAGES; k++) begin
            pc_q[k]   <= pc_q[k-1];
            pt_q[k]   <= pt_q[k-1];
            ptgt_q[k] <= ptgt_q[k-1];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mispredict_q <= 1'b0;
         redirect_q   <= 32'd0;
      end else begin
         mispredict_q <= mispredict_d;
         redirect_q   <= redirect_d;
      end
   end

   assign mispredict  = mispredict_q;
   assign redirect_pc = redirect_q;

   // FIFO control: a push into a full FIFO survives only if the head is
   // accepted in the same cycle.
   always_comb begin
      not_empty = (cnt_q != '0);
      full      = (cnt_q == DEPTH_C);
      pop       = not_empty && upd_ready;
      accept    = push && (!full || pop);
      drop      = push && full && !pop;
      cnt_d     = cnt_q;
      if (accept && !pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!accept && pop) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_q      <= '0;
         rd_q      <= '0;
         cnt_q     <= '0;
         dropped_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
         if (accept) begin
            wr_q <= wr_q + 1'b1;
         end
         if (pop) begin
            rd_q <= rd_q + 1'b1;
         end
         if (drop && dropped_q != 16'hFFFF) begin
            dropped_q <= dropped_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (accept) begin
         mem_pc[wr_q]   <= tail_pc;
         mem_res[wr_q]  <= push_res;
         mem_addr[wr_q] <= push_addr;
      end
   end

   // Head data is gated so the write port reads all-zero when idle
   assign upd_write     = not_empty;
   assign upd_pc        = not_empty ? mem_pc[rd_q] : 32'd0;
   assign upd_result    = not_empty ? mem_res[rd_q] : 1'b0;
   assign upd_address   = not_empty ? mem_addr[rd_q] : 32'd0;
   assign fifo_full     = full;
   assign dropped_count = dropped_q;

endmodule

// File: tb/tb_branch_update_unit.sv
// tb/tb_branch_update_unit.sv - self-checking bench for branch_update_unit
module tb_branch_update_unit;

   localparam int STAGES     = 2;
   localparam int FIFO_DEPTH = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        stall;
   logic        ex_valid;
   logic        ex_is_branch;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic        upd_write;
   logic [31:0] upd_pc;
   logic        upd_result;
   logic [31:0] upd_address;
   logic        upd_ready;
   logic        fifo_full;
   logic [15:0] dropped_count;

   int vectors    = 0;
   int miscompares = 0;

   branch_update_unit #(.STAGES(STAGES), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clock(clock), .reset(reset),
      .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
      .pred_taken(pred_taken), .pred_target(pred_target),
      .stall(stall),
      .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
      .ex_taken(ex_taken), .ex_target(ex_target),
      .mispredict(mispredict), .redirect_pc(redirect_pc),
      .upd_write(upd_write), .upd_pc(upd_pc),
      .upd_result(upd_result), .upd_address(upd_address),
      .upd_ready(upd_ready), .fifo_full(fifo_full),
      .dropped_count(dropped_count)
   );

   always #5 clock = ~clock;

   // Reference model
   typedef struct {
      bit          v;
      logic [31:0] pc;
      bit          pt;
      logic [31:0] ptgt;
   } trk_t;

   typedef struct {
      logic [31:0] pc;
      bit          res;
      logic [31:0] addr;
   } upd_t;

   trk_t        trk [STAGES];
   upd_t        fifo [$];
   int          drops_m;
   bit          mis_m;
   logic [31:0] red_m;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      bit          do_eval, mis, push;
      logic [31:0] seq, red, pnext, anext;
      upd_t        u;
      if (reset) begin
         for (int k = 0; k < STAGES; k++) trk[k].v = 0;
         fifo.delete();
         drops_m = 0;
         mis_m   = 0;
         red_m   = 0;
         return;
      end
      mis  = 0;
      push = 0;
      red  = 0;
      do_eval = !stall && ex_valid && trk[STAGES-1].v;
      if (do_eval) begin
         seq = trk[STAGES-1].pc + 32'd4;
         if (ex_is_branch) begin
            pnext = trk[STAGES-1].pt ? trk[STAGES-1].ptgt : seq;
            anext = ex_taken ? ex_target : seq;
            mis   = (pnext != anext);
            red   = anext;
            push  = 1;
            u.pc = trk[STAGES-1].pc; u.res = ex_taken; u.addr = ex_target;
         end else if (trk[STAGES-1].pt) begin
            mis  = 1;
            red  = seq;
            push = 1;
            u.pc = trk[STAGES-1].pc; u.res = 0; u.addr = seq;
         end
      end
      if (fifo.size() > 0 && upd_ready) void'(fifo.pop_front());
      if (push) begin
         if (fifo.size() < FIFO_DEPTH) fifo.push_back(u);
         else if (drops_m < 65535) drops_m++;
      end
      if (!stall) begin
         for (int k = STAGES - 1; k > 0; k--) trk[k] = trk[k-1];
         trk[0].v = fetch_valid; trk[0].pc = fetch_pc;
         trk[0].pt = pred_taken; trk[0].ptgt = pred_target;
         if (mis) for (int k = 0; k < STAGES; k++) trk[k].v = 0;
      end
      mis_m = mis;
      if (mis) red_m = red;
   endtask

   task automatic check_model();
      bit ne;
      ne = fifo.size() > 0;
      chk("mispredict", {31'd0, mispredict}, {31'd0, mis_m});
      chk("redirect_pc", redirect_pc, red_m);
      chk("upd_write", {31'd0, upd_write}, {31'd0, ne});
      chk("upd_pc", upd_pc, ne ? fifo[0].pc : 32'd0);
      chk("upd_result", {31'd0, upd_result}, {31'd0, ne ? fifo[0].res : 1'b0});
      chk("upd_address", upd_address, ne ? fifo[0].addr : 32'd0);
      chk("fifo_full", {31'd0, fifo_full}, {31'd0, fifo.size() == FIFO_DEPTH});
      chk("dropped_count", {16'd0, dropped_count}, drops_m);
   endtask

   task automatic cycle();
      model_step();
      @(posedge clock);
      #1;
      check_model();
   endtask

   task automatic set_fetch(input bit v, input logic [31:0] pc, input bit pt, input logic [31:0] tgt);
      fetch_valid = v; fetch_pc = pc; pred_taken = pt; pred_target = tgt;
   endtask

   task automatic set_ex(input bit v, input bit br, input bit tk, input logic [31:0] tgt);
      ex_valid = v; ex_is_branch = br; ex_taken = tk; ex_target = tgt;
   endtask

   task automatic idle();
      set_fetch(0, 0, 0, 0);
      set_ex(0, 0, 0, 0);
      stall = 0;
   endtask

   initial begin
      for (int k = 0; k < STAGES; k++) begin
         trk[k].v = 0; trk[k].pc = 0; trk[k].pt = 0; trk[k].ptgt = 0;
      end
      drops_m = 0; mis_m = 0; red_m = 0;
      idle();
      upd_ready = 0;
      reset = 1;
      #1;
      cycle();
      cycle();
      reset = 0;
      chk("reset_upd_write", {31'd0, upd_write}, 32'd0);
      chk("reset_dropped", {16'd0, dropped_count}, 32'd0);

      // Correct taken prediction
      set_fetch(1, 32'h100, 1, 32'h200); cycle();
      idle(); cycle();
      set_ex(1, 1, 1, 32'h200); cycle();
      chk("t1_no_mispredict", {31'd0, mispredict}, 32'd0);
      chk("t1_upd_pc", upd_pc, 32'h100);
      chk("t1_upd_result", {31'd0, upd_result}, 32'd1);
      chk("t1_upd_address", upd_address, 32'h200);
      idle(); upd_ready = 1; cycle();
      chk("t1_drained", {31'd0, upd_write}, 32'd0);

      // Direction mispredict, with a fetch in the flush cycle that must die
      upd_ready = 0;
      set_fetch(1, 32'h40, 0, 32'h999); cycle();
      idle(); cycle();
      set_ex(1, 1, 1, 32'h80); set_fetch(1, 32'h44, 1, 32'h700); cycle();
      chk("t2_mispredict", {31'd0, mispredict}, 32'd1);
      chk("t2_redirect", redirect_pc, 32'h80);
      chk("t2_upd_pc", upd_pc, 32'h40);
      chk("t2_upd_address", upd_address, 32'h80);
      idle(); cycle();
      chk("t2_pulse_one_cycle", {31'd0, mispredict}, 32'd0);
      set_ex(1, 0, 0, 0); cycle();
      chk("t2_flushed_entry", {31'd0, mispredict}, 32'd0);
      idle(); upd_ready = 1; cycle();

      // Aliased non-branch
      upd_ready = 0;
      set_fetch(1, 32'h10, 1, 32'h300); cycle();
      idle(); cycle();
      set_ex(1, 0, 0, 0); cycle();
      chk("t3_mispredict", {31'd0, mispredict}, 32'd1);
      chk("t3_redirect", redirect_pc, 32'h14);
      chk("t3_upd_result", {31'd0, upd_result}, 32'd0);
      chk("t3_upd_address", upd_address, 32'h14);

      // Stall freezes the tail; FIFO still drains
      set_fetch(1, 32'h500, 1, 32'h600); set_ex(0, 0, 0, 0); cycle();
      idle(); cycle();
      stall = 1; upd_ready = 1; set_ex(1, 0, 0, 0);
      set_fetch(1, 32'h900, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("t4_stall_no_mispredict", {31'd0, mispredict}, 32'd0);
      end
      chk("t4_fifo_drained", {31'd0, upd_write}, 32'd0);
      stall = 0; upd_ready = 0; set_fetch(0, 0, 0, 0); cycle();
      chk("t4_release_mispredict", {31'd0, mispredict}, 32'd1);
      chk("t4_release_redirect", redirect_pc, 32'h504);
      idle(); upd_ready = 1; cycle(); cycle();

      // FIFO overflow
      upd_ready = 0;
      for (int i = 0; i < 8; i++) begin
         set_fetch(1, 32'h1000 + 32'(4 * i), 0, 0);
         set_ex(1, 1, 0, 32'h0);
         cycle();
      end
      chk("t5_full", {31'd0, fifo_full}, 32'd1);
      chk("t5_dropped", {16'd0, dropped_count}, 32'd2);
      chk("t5_head", upd_pc, 32'h1000);
      set_fetch(0, 0, 0, 0); upd_ready = 1; cycle();
      chk("t5_pushpop_full", {31'd0, fifo_full}, 32'd1);
      chk("t5_pushpop_nodrop", {16'd0, dropped_count}, 32'd2);
      chk("t5_pushpop_head", upd_pc, 32'h1004);
      idle(); for (int i = 0; i < 5; i++) cycle();

      // Reset mid-operation
      upd_ready = 0;
      for (int i = 0; i < 5; i++) begin
         set_fetch(1, 32'h2000 + 32'(4 * i), 1, 32'h3000);
         set_ex(1, 1, 1, 32'h3000);
         cycle();
      end
      set_fetch(0, 0, 0, 0); set_ex(1, 1, 0, 0); reset = 1; cycle();
      reset = 0; idle();
      chk("t6_upd_write", {31'd0, upd_write}, 32'd0);
      chk("t6_upd_pc", upd_pc, 32'd0);
      chk("t6_mispredict", {31'd0, mispredict}, 32'd0);
      chk("t6_redirect", redirect_pc, 32'd0);
      chk("t6_dropped", {16'd0, dropped_count}, 32'd0);
      cycle();
      chk("t6_no_late_pulse", {31'd0, mispredict}, 32'd0);

      // Wrap-around PC: 0xFFFFFFFC falls through to 0
      set_fetch(1, 32'hFFFF_FFFC, 1, 32'h40); cycle();
      idle(); cycle();
      set_ex(1, 0, 0, 0); cycle();
      chk("wrap_redirect", redirect_pc, 32'h0);
      idle(); upd_ready = 1; cycle();

      // Randomized phase
      for (int n = 0; n < 600; n++) begin
         reset        = ($urandom_range(99) < 2);
         stall        = ($urandom_range(99) < 15);
         fetch_valid  = ($urandom_range(99) < 80);
         fetch_pc     = ($urandom_range(9) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
         pred_taken   = $urandom_range(1);
         pred_target  = $urandom() & 32'hFFFF_FFFC;
         ex_valid     = ($urandom_range(99) < 75);
         ex_is_branch = ($urandom_range(99) < 65);
         ex_taken     = $urandom_range(1);
         ex_target    = ($urandom_range(1) == 1) ? trk[STAGES-1].ptgt : ($urandom() & 32'hFFFF_FFFC);
         upd_ready    = ($urandom_range(99) < 40);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/branch_update_unit.md
# branch_update_unit

Writer-side companion to the fetch-stage branch prediction table. Carries each fetch-time prediction (PC, taken bit, target) down a tracking pipeline to execute and compares it with the resolved outcome. Raises a registered mispredict/redirect to the front end. Queues training updates into a small FIFO that drives the table's write port (write, pc_write, branch_result, branch_address).

## Interface
- STAGES, 2, fetch-to-execute distance in cycles; entries in tracking pipeline (>=1)
- FIFO_DEPTH, 4, update FIFO entries (power of two, >=2)
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- fetch_valid  in  1  fetch slot holds a real instruction this cycle
- fetch_pc  in  32  PC of fetched instruction
- pred_taken  in  1  table prediction for fetch_pc
- pred_target  in  32  table target for fetch_pc
- stall  in  1  freezes tracking pipeline and suppresses evaluation
- ex_valid  in  1  execute stage holds a valid instruction
- ex_is_branch  in  1  execute instruction is a conditional branch
- ex_taken  in  1  resolved direction
- ex_target  in  32  resolved taken target
- mispredict  out  1  one-cycle pulse: front end must flush and redirect
- redirect_pc  out  32  correct next PC, valid while mispredict=1
- upd_write  out  1  FIFO head valid (table write request)
- upd_pc  out  32  head PC (to pc_write)
- upd_result  out  1  head outcome (to branch_result)
- upd_address  out  32  head target (to branch_address)
- upd_ready  in  1  table accepts head this cycle
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries
- dropped_count  out  16  updates discarded on full FIFO, saturating

## Operation
- Tracking pipeline: STAGES entries {v, pc, pt, ptgt}. When stall=0, each edge: entry0 <- {fetch_valid, fetch_pc, pred_taken, pred_target}; entry[k] <- entry[k-1]. When stall=1, all entries hold.
- Last entry (tail) describes the execute instruction in the same cycle.
- Evaluate when stall=0, ex_valid=1, tail.v=1. seq = tail.pc + 4 (mod 2^32).
  - Branch: pred_next = pt ? ptgt : seq; act_next = ex_taken ? ex_target : seq. Mismatch -> mispredict, redirect_pc = act_next. Always push {tail.pc, ex_taken, ex_target}.
  - Non-branch with pt=1: mispredict, redirect_pc = seq; push {tail.pc, 0, seq} to train down.
  - Non-branch with pt=0: no action.
- ex_valid=1 with tail.v=0: no evaluation, no push (untracked instruction).
- Flush: on the edge that sets mispredict, all tracking v bits clear, including the entry shifting in.
- FIFO: upd_write = not empty; head presented on upd_* outputs. Pop when upd_write & upd_ready.
  - Push with room: append. Push when full: pop accepted same cycle -> append; otherwise drop and increment dropped_count (saturate 0xFFFF).
  - FIFO drains regardless of stall; stall never affects upd_*.
- Reset: tracking v bits, FIFO pointers/count, mispredict, redirect_pc, upd_* (upd_write=0, data 0), fifo_full, dropped_count all 0. Reset mid-drain discards queued updates; reset overrides a concurrent evaluation.

## Timing
- Evaluation combinational in cycle N. mispredict/redirect_pc are registered and valid in cycle N+1 for exactly one cycle.
- Push at edge ending cycle N; upd_write=1 earliest in cycle N+1. Throughput: one pop per cycle.
- Fetch at cycle F reaches tail at cycle F+STAGES, given no stall or flush.
- Back-to-back mispredicts impossible: the flush clears tail, so the next evaluation is >= STAGES+1 cycles later.
- pc wrap: 0xFFFFFFFC + 4 = 0x00000000.

## Test plan
- Correct taken: fetch pc=0x100 pt=1 ptgt=0x200; after 2 cycles ex_is_branch=1 taken=1 target=0x200 -> no mispredict; next cycle upd_write=1, upd_pc=0x100, upd_result=1, upd_address=0x200; upd_ready=1 empties FIFO.
- Direction mispredict: pc=0x40 pt=0, resolves taken to 0x80 -> cycle later mispredict=1 for one cycle, redirect_pc=0x80, all tracking v=0; update {0x40,1,0x80} queued.
- Aliased non-branch: pc=0x10 pt=1 ptgt=0x300, ex_is_branch=0 -> mispredict, redirect_pc=0x14, update {0x10,0,0x14}.
- Stall: stall=1 for 3 cycles with ex_valid=1 on tail -> no mispredict, no push, entries unchanged; FIFO still pops with upd_ready=1.
- FIFO overflow: upd_ready=0, 6 resolved branches with FIFO_DEPTH=4 -> fifo_full=1 after 4th, dropped_count=2, head still first PC; simultaneous push+pop when full -> count stays 4, no drop.
- Reset mid-operation: 3 queued updates plus a pending evaluation, reset=1 one cycle -> next cycle all outputs 0, dropped_count=0, no mispredict pulse.
